// File: rtl/fir_pkg.sv
// Shared constants and FSM state encoding for the FIR coefficient loader.
package fir_pkg;

  localparam int DEF_TAP_COEFF_WIDTH = 5;
  localparam int DEF_NUM_TAPS        = 50;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2,
    ST_FLUSH   = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair: single write port into the shadow
// bank and a bulk copy that moves the whole shadow set to the active bank.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int W  = DEF_TAP_COEFF_WIDTH,
  parameter int N  = DEF_NUM_TAPS,
  parameter int AW = $clog2(DEF_NUM_TAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [W-1:0]    i_wr_data,
  input  logic            i_copy,
  output logic [W*N-1:0]  o_active
);

  logic [W-1:0] r_shadow [N];
  logic [W-1:0] r_active [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      // Caller guarantees i_wr_addr < N whenever i_wr_en is high.
      if (i_wr_en) begin
        r_shadow[i_wr_addr] <= i_wr_data;
      end
      if (i_copy) begin
        r_active <= r_shadow;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign o_active[W*g +: W] = r_active[g];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: collects a coefficient set, swaps it
// in atomically on a sample boundary, then holds off coeff_stable while the pipe drains.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int TAP_COEFF_WIDTH = DEF_TAP_COEFF_WIDTH,
  parameter int NUM_TAPS        = DEF_NUM_TAPS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [$clog2(NUM_TAPS)-1:0]         cfg_addr,
  input  logic [TAP_COEFF_WIDTH-1:0]          cfg_data,
  input  logic                                cfg_last,
  input  logic                                swap_en,
  output logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs,
  output logic                                coeff_stable,
  output logic                                busy,
  output logic                                cfg_err,
  output fir_state_e                          o_dbg_state
);

  localparam int              AW         = $clog2(NUM_TAPS);
  localparam logic [AW:0]     NUM_TAPS_X = (AW+1)'(NUM_TAPS);
  localparam logic [AW-1:0]   FLUSH_LOAD = AW'(NUM_TAPS - 1);

  // Handshake: a write transfers on any edge where cfg_valid && cfg_ready;
  // cfg_valid may be held while cfg_ready is low and the write waits.
  fir_state_e      r_state;
  logic [AW-1:0]   r_flush_cnt;
  logic            r_cfg_ready;
  logic            r_coeff_stable;
  logic            r_busy;
  logic            r_cfg_err;

  logic            w_accept;
  logic            w_oob;
  logic            w_wr_en;
  logic            w_swap;

  assign w_accept = cfg_valid && r_cfg_ready;
  assign w_oob    = {1'b0, cfg_addr} >= NUM_TAPS_X;
  assign w_wr_en  = w_accept && !w_oob;
  assign w_swap   = (r_state == ST_PENDING) && swap_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_flush_cnt    <= '0;
      r_cfg_ready    <= 1'b1;
      r_coeff_stable <= 1'b1;
      r_busy         <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && w_oob;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (cfg_last) begin
              r_state     <= ST_PENDING;
              r_cfg_ready <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_PENDING: begin
          if (swap_en) begin
            r_state        <= ST_FLUSH;
            r_flush_cnt    <= FLUSH_LOAD;
            r_coeff_stable <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // One cycle per tap so no sample computed with the old set survives.
          if (r_flush_cnt == '0) begin
            r_state        <= ST_IDLE;
            r_cfg_ready    <= 1'b1;
            r_coeff_stable <= 1'b1;
            r_busy         <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  fir_coeff_bank #(
    .W  (TAP_COEFF_WIDTH),
    .N  (NUM_TAPS),
    .AW (AW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_data),
    .i_copy    (w_swap),
    .o_active  (tap_coeffs)
  );

  assign cfg_ready    = r_cfg_ready;
  assign coeff_stable = r_coeff_stable;
  assign busy         = r_busy;
  assign cfg_err      = r_cfg_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: table-driven load/swap sequence plus
// hand-written backpressure, simultaneity and mid-flush reset sequences.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int W  = 5;
  localparam int N  = 50;
  localparam int AW = 6;

  logic            clk;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [AW-1:0]   cfg_addr;
  logic [W-1:0]    cfg_data;
  logic            cfg_last;
  logic            swap_en;
  logic [W*N-1:0]  tap_coeffs;
  logic            coeff_stable;
  logic            busy;
  logic            cfg_err;
  fir_state_e      dbg_state;

  fir_coeff_loader #(
    .TAP_COEFF_WIDTH (W),
    .NUM_TAPS        (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .swap_en      (swap_en),
    .tap_coeffs   (tap_coeffs),
    .coeff_stable (coeff_stable),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .o_dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;
  logic [W-1:0] m_act [N];

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          last;
    logic          swap;
    logic          e_ready;
    logic          e_busy;
    logic          e_stable;
    logic          e_err;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic l, input logic s);
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_last  = l;
    swap_en   = s;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [W*N-1:0] exp_taps();
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = m_act[i];
    return r;
  endfunction

  task automatic chk_taps(input string name);
    logic [W*N-1:0] e;
    e = exp_taps();
    n_total++;
    if (tap_coeffs !== e) $display("FAIL %s: got %h expected %h", name, tap_coeffs, e);
    else n_pass++;
  endtask

  // Counts FLUSH samples until coeff_stable rises; also tracks cfg_ready leaks.
  task automatic wait_flush(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    while (coeff_stable !== 1'b1 && n < 200) begin
      if (cfg_ready !== 1'b0) rdy_bad++;
      n++;
      step();
    end
  endtask

  int n_low;
  int n_bad;

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < N; i++) m_act[i] = '0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset
    step();
    step();
    rst = 1'b0;
    step();
    chk_taps("reset_taps");
    chk("reset_ready", cfg_ready, 1);
    chk("reset_stable", coeff_stable, 1);
    chk("reset_busy", busy, 0);
    chk("reset_err", cfg_err, 0);
    chk("reset_state", dbg_state, ST_IDLE);

    // Out-of-range write, load taps 0..3 = 3 (swap_en in LOAD ignored), swap 5 cycles after last
    tbl[0] = '{1'b1, 6'd50, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 6'd0,  5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 6'd1,  5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 6'd2,  5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 6'd3,  5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 6'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 6'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 6'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 6'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 6'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].valid, tbl[i].addr, tbl[i].data, tbl[i].last, tbl[i].swap);
      step();
      chk($sformatf("v%0d_ready", i), cfg_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_stable", i), coeff_stable, tbl[i].e_stable);
      chk($sformatf("v%0d_err", i), cfg_err, tbl[i].e_err);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) m_act[i] = 5'd3;
    chk_taps("swap1_taps");
    wait_flush(n_low, n_bad);
    chk("swap1_low_cycles", n_low, 50);
    chk("swap1_state", dbg_state, ST_IDLE);
    chk("swap1_busy", busy, 0);
    chk("swap1_ready", cfg_ready, 1);
    chk_taps("swap1_taps_after_flush");

    // Backpressure: write held through PENDING/FLUSH lands in first IDLE cycle
    drive(1'b1, 6'd5, 5'h1F, 1'b1, 1'b0);
    step();
    chk("bp_pend_state", dbg_state, ST_PENDING);
    drive(1'b1, 6'd6, 5'd7, 1'b0, 1'b0);
    step();
    chk("bp_pend_ready", cfg_ready, 0);
    swap_en = 1'b1;
    step();
    swap_en = 1'b0;
    m_act[5] = 5'h1F;
    chk_taps("bp_swap_taps");
    wait_flush(n_low, n_bad);
    chk("bp_low_cycles", n_low, 50);
    chk("bp_ready_leaks", n_bad, 0);
    chk("bp_idle_state", dbg_state, ST_IDLE);
    chk("bp_idle_ready", cfg_ready, 1);
    step();
    chk("bp_accept_state", dbg_state, ST_LOAD);
    chk("bp_accept_busy", busy, 1);
    chk_taps("bp_taps_unchanged");

    // cfg_last and swap_en together: no swap; next swap_en swaps
    drive(1'b1, 6'd7, 5'd1, 1'b1, 1'b1);
    step();
    chk("sim_state", dbg_state, ST_PENDING);
    chk("sim_stable", coeff_stable, 1);
    chk_taps("sim_taps_unchanged");
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sim_swap_stable", coeff_stable, 0);
    m_act[6] = 5'd7;
    m_act[7] = 5'd1;
    chk_taps("sim_swap_taps");
    wait_flush(n_low, n_bad);
    chk("sim_low_cycles", n_low, 50);

    // Reset asserted with flush count at 20
    drive(1'b1, 6'd0, 5'h1B, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    swap_en = 1'b0;
    m_act[0] = 5'h1B;
    chk_taps("mr_swap_taps");
    repeat (29) step();
    chk("mr_before_stable", coeff_stable, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_act[i] = '0;
    chk_taps("mr_taps");
    chk("mr_state", dbg_state, ST_IDLE);
    chk("mr_stable", coeff_stable, 1);
    chk("mr_ready", cfg_ready, 1);
    chk("mr_busy", busy, 0);

    // Shadow must also be cleared by reset: only tap 1 is written afterwards
    drive(1'b1, 6'd1, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    m_act[1] = 5'd2;
    chk_taps("mr_shadow_cleared");
    wait_flush(n_low, n_bad);
    chk("mr_final_state", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter TAP_COEFF_WIDTH, default 5: coefficient width in bits, signed.
REQ-002 SHALL have parameter NUM_TAPS, default 50: number of taps driven into the transposed FIR pipe.
REQ-003 SHALL have port clk, input, 1: single clock for all state.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid, input, 1: coefficient write request.
REQ-006 SHALL have port cfg_ready, output, 1: loader accepts a write this cycle.
REQ-007 SHALL have port cfg_addr, input, $clog2(NUM_TAPS): tap index.
REQ-008 SHALL have port cfg_data, input, TAP_COEFF_WIDTH: signed coefficient value.
REQ-009 SHALL have port cfg_last, input, 1: marks the final write of a coefficient set.
REQ-010 SHALL have port swap_en, input, 1: sample-boundary strobe that permits a coefficient swap.
REQ-011 SHALL have port tap_coeffs, output, TAP_COEFF_WIDTH*NUM_TAPS: flattened active set; tap i at bits [W*(i+1)-1:W*i].
REQ-012 SHALL have port coeff_stable, output, 1: high when the FIR pipe holds no samples computed with the previous set.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port cfg_err, output, 1: one-cycle pulse on an accepted write with cfg_addr >= NUM_TAPS.

Function
REQ-015 SHALL keep two banks: a shadow bank (write target) and an active bank (drives tap_coeffs, registered).
REQ-016 SHALL implement FSM states IDLE, LOAD, PENDING, FLUSH.
REQ-017 SHALL drive cfg_ready=1 in IDLE and LOAD, and 0 in PENDING and FLUSH.
REQ-018 SHALL accept a write only when cfg_valid && cfg_ready; shadow[cfg_addr] <= cfg_data at that edge.
REQ-019 SHALL ignore the data of an accepted write with an out-of-range address and pulse cfg_err the following cycle; cfg_last on such a write still takes effect.
REQ-020 SHALL transition IDLE->LOAD on an accepted write without cfg_last, and IDLE/LOAD->PENDING on an accepted write with cfg_last.
REQ-021 SHALL retain previous values in shadow entries not written in a set.
REQ-022 SHALL, in PENDING with swap_en=1, copy all shadow entries into the active bank at that edge (tap_coeffs updates the next cycle, all taps atomically), load the flush counter with NUM_TAPS-1, and enter FLUSH.
REQ-023 SHALL ignore swap_en outside PENDING, including the cycle in which cfg_last is accepted.
REQ-024 SHALL hold coeff_stable=0 from the swap edge until the flush counter reaches 0, i.e. for NUM_TAPS cycles; at count 0 SHALL enter IDLE with coeff_stable=1.
REQ-025 SHALL keep tap_coeffs constant except on the swap edge.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, clear shadow and active banks to 0, enter IDLE, and drive cfg_ready=1, coeff_stable=1, busy=0, cfg_err=0; rst SHALL take priority over all other inputs in every state.

Structure
REQ-027 SHALL place the FSM state enum typedef and the default TAP_COEFF_WIDTH/NUM_TAPS constants in shared package fir_pkg.
REQ-028 SHALL implement the shadow/active register pair in a sub-module fir_coeff_bank (write port, bulk-copy strobe, flattened active output).

Verification
REQ-029 SHALL verify reset: rst high 2 cycles, then low -> tap_coeffs=0, cfg_ready=1, coeff_stable=1, busy=0.
REQ-030 SHALL verify load and swap: write 3 to taps 0..3 with cfg_last on addr 3, swap_en 5 cycles later -> taps 0..3=3 and taps 4..49=0 one cycle after the swap edge; coeff_stable low exactly 50 cycles, then IDLE.
REQ-031 SHALL verify backpressure: cfg_valid held high through PENDING/FLUSH with data 7 -> no shadow change, cfg_ready=0 until IDLE; the held write is accepted in the first IDLE cycle.
REQ-032 SHALL verify an out-of-range write: write addr 50, data 5 -> one-cycle cfg_err pulse, shadow unchanged.
REQ-033 SHALL verify simultaneity: cfg_last and swap_en in the same cycle -> no swap; the next swap_en pulse swaps.
REQ-034 SHALL verify mid-operation reset: rst asserted at flush count 20 -> next cycle all taps 0, IDLE, coeff_stable=1.
